prio_enc_seq: RTL and testbench
===============================

# prio_enc_seq

Parametrised sequential priority encoder that captures an N-bit request vector and emits the index of every set bit, highest first, one per valid/ready handshake. It generalises the 8-to-3 priority encoder of the encode2seg path: width is a parameter, results are registered, and a loaded vector is drained bit by bit instead of reporting only the top bit. It sits between switch/request sources and the index consumer, such as the seven-segment display driver.

## Interface
- N, default 8: request vector width; legal range 2..64.
- IDX_W, default $clog2(N): index width; derived, never overridden.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  block enable; low means synchronous flush.
- load  in  1  capture data_in this cycle (honoured only when !busy).
- data_in  in  N  request vector; bit N-1 has highest priority.
- out_valid  out  1  idx_out holds a pending index.
- out_ready  in  1  consumer accepts idx_out.
- idx_out  out  IDX_W  index of highest pending bit.
- any_out  out  1  last captured vector was non-zero (Ys indicator).
- busy  out  1  state is SCAN.
- remain  out  IDX_W+1  set bits still pending, including the one on idx_out.
- seg_out  out  8  only with PRIO_ENC_SEG_EN; active-low segments {dp,g..a}.

## Operation
- States: IDLE and SCAN. Internal pending mask pend[N-1:0].
- Reset, asynchronous:
  - state=IDLE, pend=0.
  - out_valid=0, idx_out=0, any_out=0, busy=0, remain=0.
  - seg_out=8'hFF.
- en=0, synchronous and highest priority:
  - State goes to IDLE and pend is cleared.
  - out_valid=0, idx_out=0, any_out=0, remain=0.
  - load and out_ready are ignored.
- IDLE with en && load:
  - data_in!=0: pend<=data_in; any_out<=1; idx_out<=highest set bit; remain<=popcount(data_in); out_valid<=1; go to SCAN.
  - data_in==0: any_out<=0; idx_out<={IDX_W{1'b1}}; remain<=0; stay in IDLE; out_valid stays 0.
- SCAN with out_valid && out_ready:
  - Clear bit idx_out in pend and decrement remain.
  - If the updated pend!=0: idx_out<=highest set bit of the updated pend.
  - Otherwise: out_valid<=0, go to IDLE, idx_out holds the last index.
- SCAN without a handshake: all outputs are held stable. idx_out and remain must not change while out_valid=1 && !out_ready.
- load during SCAN is ignored. data_in changes are not observed after capture.
- any_out holds until the next accepted load, en=0, or reset.
- The priority search is a combinational highest-set-bit over pend (or over data_in on load), registered into idx_out. Any N up to 64 is supported; a casex ladder is not permitted.

## Timing
- Load to first index: 1 cycle. load is sampled at edge k; out_valid, idx_out, remain and any_out are valid after edge k.
- Throughput: one index per cycle while out_ready=1. A vector with P set bits drains in P cycles.
- Last handshake at edge m: out_valid=0 and busy=0 after edge m. A new load is honoured from edge m+1.
- Reset is asynchronous assert. Deassertion is expected synchronous to clk externally. Reset mid-SCAN discards pend.
- en falling mid-SCAN takes effect at the next edge, even if out_ready is high that cycle.

## Configuration
- PRIO_ENC_SEG_EN defined:
  - Adds the seg_out port, registered from the next-state values, so it is updated in the same edge as idx_out.
  - When the next out_valid=1, seg_out shows the hex digit of idx_out[3:0] (0–F), active-low, with dp off.
  - Otherwise seg_out=8'hFF (all segments off).
  - For N>16 only the low nibble is displayed.
- PRIO_ENC_SEG_EN undefined: seg_out and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then load 8'b1010_0010 with ready=1: idx_out sequence 7,5,1 on three consecutive cycles; remain 3,2,1; out_valid drops the next cycle and any_out=1.
- Load 8'h00: any_out=0, idx_out=3'b111, out_valid stays 0, busy stays 0.
- Load 8'hFF with ready held low for 5 cycles: idx_out=7 and remain=8 stay stable. Pulse load with 8'h01 during the stall: it is ignored.
- Mid-drain of 8'hC3: drop en for one cycle. All outputs go to 0 and the next load of 8'h10 yields idx_out=4.
- N=32: load 32'h8000_0001 with ready=1 to get idx 31 then 0. Assert rst_n=0 mid-drain: outputs clear immediately, without waiting for an edge.
- With PRIO_ENC_SEG_EN: load 8'h20 gives seg_out=~8'h6D (digit 5). After the handshake, seg_out=8'hFF.

Source files
------------

// File: rtl/prio_enc_seq.sv
// prio_enc_seq: sequential priority encoder. Captures an N-bit request vector
// and hands out the index of every set bit, highest first, one per
// out_valid/out_ready handshake.
// Optional build macro PRIO_ENC_SEG_EN adds a registered active-low
// seven-segment view (seg_out) of the index being presented.
module prio_enc_seq #(
  parameter int  N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [N-1:0]     data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] idx_out,
  output logic             any_out,
  output logic             busy,
  output logic [IDX_W:0]   remain
`ifdef PRIO_ENC_SEG_EN
  ,
  output logic [7:0]       seg_out
`endif
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     pend_q, pend_d, pend_clr;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   rem_q, rem_d;
  logic             vld_q, vld_d;
  logic             any_q, any_d;

  // Highest set bit: later (higher) hits overwrite earlier ones, so the loop
  // scales to any N without a hand-written ladder.
  function automatic logic [IDX_W-1:0] hsb(input logic [N-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (v[i]) r = IDX_W'(i);
    return r;
  endfunction

  function automatic logic [IDX_W:0] popcnt(input logic [N-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < N; i++)
      c = c + {{IDX_W{1'b0}}, v[i]};
    return c;
  endfunction

  // Next-state: flush on !en, capture in IDLE, retire one bit per handshake in SCAN
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    vld_d    = vld_q;
    any_d    = any_q;
    pend_clr = pend_q;
    pend_clr[idx_q] = 1'b0;
    if (!en) begin
      state_d = IDLE;
      pend_d  = '0;
      idx_d   = '0;
      rem_d   = '0;
      vld_d   = 1'b0;
      any_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            if (|data_in) begin
              pend_d  = data_in;
              any_d   = 1'b1;
              idx_d   = hsb(data_in);
              rem_d   = popcnt(data_in);
              vld_d   = 1'b1;
              state_d = SCAN;
            end else begin
              // Empty vector: report "nothing" without entering SCAN
              any_d = 1'b0;
              idx_d = '1;
              rem_d = '0;
            end
          end
        end
        SCAN: begin
          if (vld_q && out_ready) begin
            pend_d = pend_clr;
            rem_d  = rem_q - {{IDX_W{1'b0}}, 1'b1};
            if (|pend_clr) begin
              idx_d = hsb(pend_clr);
            end else begin
              // Drained: idx_out keeps the last index handed out
              vld_d   = 1'b0;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      vld_q   <= 1'b0;
      any_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      vld_q   <= vld_d;
      any_q   <= any_d;
    end
  end

  assign out_valid = vld_q;
  assign idx_out   = idx_q;
  assign any_out   = any_q;
  assign busy      = (state_q == SCAN);
  assign remain    = rem_q;

`ifdef PRIO_ENC_SEG_EN
  logic [7:0] seg_q, seg_d;
  logic [3:0] nib;

  // Segment pattern {g,f,e,d,c,b,a}, active-high, for hex digits 0..F
  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
      4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
      4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Decode from next-state so the display changes on the same edge as idx_out
  always_comb begin
    nib   = 4'(idx_d);
    seg_d = vld_d ? {1'b1, ~hex7(nib)} : 8'hFF;
  end

  // Display register, blank out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seg_q <= 8'hFF;
    else        seg_q <= seg_d;
  end

  assign seg_out = seg_q;
`endif

endmodule

// File: tb/tb_prio_enc_seq.sv
// Bench for prio_enc_seq: an N=8 and an N=32 instance driven by directed steps
// and random traffic, checked against a list-of-indices reference model.
module tb_prio_enc_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_en, a_ld, a_rdy, a_vld, a_any, a_busy;
  logic [7:0]  a_data;
  logic [2:0]  a_idx;
  logic [3:0]  a_rem;
  logic        b_en, b_ld, b_rdy, b_vld, b_any, b_busy;
  logic [31:0] b_data;
  logic [4:0]  b_idx;
  logic [5:0]  b_rem;
`ifdef PRIO_ENC_SEG_EN
  logic [7:0]  a_seg, b_seg;
`endif

  always #5 clk = ~clk;

  prio_enc_seq #(.N(8)) u_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .load(a_ld), .data_in(a_data),
    .out_valid(a_vld), .out_ready(a_rdy), .idx_out(a_idx), .any_out(a_any),
    .busy(a_busy), .remain(a_rem)
`ifdef PRIO_ENC_SEG_EN
    , .seg_out(a_seg)
`endif
  );

  prio_enc_seq #(.N(32)) u_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .load(b_ld), .data_in(b_data),
    .out_valid(b_vld), .out_ready(b_rdy), .idx_out(b_idx), .any_out(b_any),
    .busy(b_busy), .remain(b_rem)
`ifdef PRIO_ENC_SEG_EN
    , .seg_out(b_seg)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;
  int stp = 0;

  // Reference model: the captured vector as a descending list of indices,
  // with a head pointer marking the one currently offered.
  int lst[2][64];
  int cnt[2];
  int hd[2];
  int m_idx[2];
  bit m_any[2];
  bit m_vld[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s step=%0d obs=%0h exp=%0h", tag, stp, obs, exp);
  endtask

  function automatic logic [7:0] seg_exp(input bit v, input int idx);
    logic [6:0] s;
    logic [3:0] d;
    d = 4'(idx);
    case (d)
      4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
      4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
      4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
    endcase
    return v ? ~{1'b0, s} : 8'hFF;
  endfunction

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      cnt[d] = 0; hd[d] = 0; m_idx[d] = 0; m_any[d] = 0; m_vld[d] = 0;
    end
  endtask

  task automatic mdl(input int d, input int w, input int iw, input logic en,
                     input logic ld, input logic [63:0] data, input logic rdy);
    if (!en) begin
      cnt[d] = 0; hd[d] = 0; m_idx[d] = 0; m_any[d] = 0; m_vld[d] = 0;
    end else if (!m_vld[d]) begin
      if (ld) begin
        if (data == 0) begin
          m_any[d] = 0;
          m_idx[d] = (1 << iw) - 1;
        end else begin
          cnt[d] = 0; hd[d] = 0;
          for (int i = w - 1; i >= 0; i--)
            if (data[i]) begin lst[d][cnt[d]] = i; cnt[d]++; end
          m_any[d] = 1; m_vld[d] = 1;
          m_idx[d] = lst[d][0];
        end
      end
    end else if (rdy) begin
      hd[d]++;
      if (hd[d] < cnt[d]) m_idx[d] = lst[d][hd[d]];
      else m_vld[d] = 0;
    end
  endtask

  task automatic chk_all();
    chk("a_vld", a_vld, m_vld[0]);
    chk("a_idx", a_idx, m_idx[0]);
    chk("a_any", a_any, m_any[0]);
    chk("a_busy", a_busy, m_vld[0]);
    chk("a_rem", a_rem, m_vld[0] ? cnt[0] - hd[0] : 0);
    chk("b_vld", b_vld, m_vld[1]);
    chk("b_idx", b_idx, m_idx[1]);
    chk("b_any", b_any, m_any[1]);
    chk("b_busy", b_busy, m_vld[1]);
    chk("b_rem", b_rem, m_vld[1] ? cnt[1] - hd[1] : 0);
`ifdef PRIO_ENC_SEG_EN
    chk("a_seg", a_seg, seg_exp(m_vld[0], m_idx[0]));
    chk("b_seg", b_seg, seg_exp(m_vld[1], m_idx[1]));
`endif
  endtask

  // One clock: advance model with the inputs as they will be sampled, then check
  task automatic step();
    mdl(0, 8, 3, a_en, a_ld, 64'(a_data), a_rdy);
    mdl(1, 32, 5, b_en, b_ld, 64'(b_data), b_rdy);
    @(posedge clk);
    #1;
    stp++;
    chk_all();
  endtask

  initial begin
    rst_n = 1'b0;
    a_en = 0; a_ld = 0; a_rdy = 0; a_data = '0;
    b_en = 0; b_ld = 0; b_rdy = 0; b_data = '0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    @(negedge clk) rst_n = 1'b1;
    a_en = 1; b_en = 1;

    // 8'b1010_0010 drains 7,5,1
    a_ld = 1; a_data = 8'hA2; a_rdy = 1;
    step(); chk("tp_a2_i7", a_idx, 7); chk("tp_a2_r3", a_rem, 3);
    a_ld = 0;
    step(); chk("tp_a2_i5", a_idx, 5);
    step(); chk("tp_a2_i1", a_idx, 1); chk("tp_a2_r1", a_rem, 1);
    step(); chk("tp_a2_vld0", a_vld, 0); chk("tp_a2_any", a_any, 1);

    // empty vector
    a_ld = 1; a_data = 8'h00;
    step(); chk("tp_00_any", a_any, 0); chk("tp_00_idx", a_idx, 7);
    a_ld = 0;
    step(); chk("tp_00_busy", a_busy, 0);

    // 8'hFF stalled, with an ignored load in the middle
    a_ld = 1; a_data = 8'hFF; a_rdy = 0;
    step();
    a_ld = 0;
    step(); step();
    a_ld = 1; a_data = 8'h01;
    step();
    a_ld = 0;
    step(); step();
    chk("tp_ff_stall_idx", a_idx, 7); chk("tp_ff_stall_rem", a_rem, 8);
    a_rdy = 1;
    repeat (8) step();
    chk("tp_ff_done", a_vld, 0);

    // en drop mid-drain of 8'hC3
    a_ld = 1; a_data = 8'hC3;
    step();
    a_ld = 0;
    step();
    a_en = 0;
    step(); chk("tp_en_idx", a_idx, 0); chk("tp_en_any", a_any, 0);
    a_en = 1; a_ld = 1; a_data = 8'h10;
    step(); chk("tp_en_reload", a_idx, 4);
    a_ld = 0;
    step();

`ifdef PRIO_ENC_SEG_EN
    a_ld = 1; a_data = 8'h20;
    step(); chk("tp_seg5", a_seg, ~8'h6D);
    a_ld = 0;
    step(); chk("tp_seg_off", a_seg, 8'hFF);
`endif

    // N=32: top and bottom bits
    b_ld = 1; b_data = 32'h8000_0001; b_rdy = 1;
    step(); chk("tp_b_i31", b_idx, 31);
    b_ld = 0;
    step(); chk("tp_b_i0", b_idx, 0);
    step();
    b_ld = 1; b_data = 32'hF000_000F;
    step();
    b_ld = 0;
    step();
    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    mreset();
    chk("tp_rst_bvld", b_vld, 0); chk("tp_rst_bidx", b_idx, 0);
    chk("tp_rst_brem", b_rem, 0); chk("tp_rst_bbusy", b_busy, 0);
    chk("tp_rst_bany", b_any, 0);
    @(negedge clk) rst_n = 1'b1;
    b_rdy = 0;

    // random traffic on both instances
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      a_en   = ($urandom_range(0, 19) != 0);
      a_ld   = $urandom_range(0, 1) == 1;
      a_data = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      a_rdy  = ($urandom_range(0, 3) != 0);
      b_en   = ($urandom_range(0, 29) != 0);
      b_ld   = $urandom_range(0, 1) == 1;
      b_data = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom & $urandom);
      b_rdy  = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
